// File: rtl/logic_unit_pkg.sv
// logic_unit_pkg
// Shared types and helpers for the pipelined logic unit.
//   op_e       : 3-bit opcode selecting one of eight bitwise gate functions
//   flags_t    : result flags (zero, all-ones, parity) registered with the result
//   calc_flags : derives flags_t from a result vector of up to FLAG_MAX_W bits
package logic_unit_pkg;

    // Widest result calc_flags can inspect; narrower results are
    // zero-extended and a mask marks which bits are real.
    localparam int FLAG_MAX_W = 64;

    typedef enum logic [2:0] {
        OP_NOT   = 3'd0,
        OP_AND   = 3'd1,
        OP_OR    = 3'd2,
        OP_NAND  = 3'd3,
        OP_NOR   = 3'd4,
        OP_XOR   = 3'd5,
        OP_XNOR  = 3'd6,
        OP_PASSB = 3'd7
    } op_e;

    typedef struct packed {
        logic zero;
        logic ones;
        logic par;
    } flags_t;

    // The mask lets one non-parametrised function serve any WIDTH:
    // "all ones" means every bit covered by the mask is set.
    function automatic flags_t calc_flags(
        input logic [FLAG_MAX_W-1:0] y,
        input logic [FLAG_MAX_W-1:0] mask
    );
        flags_t                f;
        logic [FLAG_MAX_W-1:0] m;
        m      = y & mask;
        f.zero = (m == '0);
        f.ones = (m == mask);
        f.par  = ^m;
        return f;
    endfunction

endpackage

// File: rtl/logic_unit_core.sv
// logic_unit_core
// Purely combinational bitwise gate array.
//   op : opcode (op_e)
//   a  : operand A (ignored by PASS B)
//   b  : operand B (ignored by NOT)
//   y  : result
module logic_unit_core
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  op_e              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    // One bitwise function per opcode; all eight encodings are covered.
    always_comb begin
        y = '0;
        unique case (op)
            OP_NOT:   y = ~a;
            OP_AND:   y = a & b;
            OP_OR:    y = a | b;
            OP_NAND:  y = ~(a & b);
            OP_NOR:   y = ~(a | b);
            OP_XOR:   y = a ^ b;
            OP_XNOR:  y = ~(a ^ b);
            OP_PASSB: y = b;
        endcase
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe
// Registered logic unit with valid/ready handshakes on both sides, a one-deep
// output register, an optional accumulator feedback path and result flags.
//   clk, rst              : rising-edge clock, synchronous active-high reset
//   in_valid / in_ready   : input handshake (in_ready is combinational)
//   in_op, in_a, in_b     : opcode and operands
//   in_acc                : use accumulator as A and write the result back
//   in_clr                : clear the accumulator on this beat
//   out_valid / out_ready : output handshake
//   out_y                 : registered result
//   out_zero/ones/par     : flags registered together with out_y
//   acc_q                 : current accumulator value
//   op_count              : accepted input beats since reset, wraps
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_acc,
    input  logic             in_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_zero,
    output logic             out_ones,
    output logic             out_par,
    output logic [WIDTH-1:0] acc_q,
    output logic [CNT_W-1:0] op_count
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_y_q, out_y_d;
    flags_t           flags_q, flags_d;
    logic [WIDTH-1:0] acc_d;
    logic [CNT_W-1:0] op_count_q, op_count_d;

    logic             accept;
    logic [WIDTH-1:0] a_eff;
    logic [WIDTH-1:0] result;

    // The output slot is free when empty or being drained this cycle, which
    // gives full throughput. Nothing is accepted while reset is held.
    assign in_ready = !rst && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    // Accumulator mode reads acc_q directly so chained beats see the value
    // written by the previous beat; in_clr in that mode starts from zero.
    always_comb begin
        a_eff = in_a;
        if (in_acc) begin
            a_eff = in_clr ? '0 : acc_q;
        end
    end

    logic_unit_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .op (op_e'(in_op)),
        .a  (a_eff),
        .b  (in_b),
        .y  (result)
    );

    // Next-state for output register, flags, accumulator and counter.
    // out_y and flags are only loaded on acceptance so they hold steady
    // under backpressure.
    always_comb begin
        out_valid_d = out_valid_q;
        out_y_d     = out_y_q;
        flags_d     = flags_q;
        acc_d       = acc_q;
        op_count_d  = op_count_q;

        if (accept) begin
            out_valid_d = 1'b1;
            out_y_d     = result;
            flags_d     = calc_flags(FLAG_MAX_W'(result),
                                     FLAG_MAX_W'({WIDTH{1'b1}}));
            op_count_d  = op_count_q + 1'b1;
            if (in_acc) begin
                acc_d = result;
            end else if (in_clr) begin
                acc_d = '0;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers; reset drops any pending result and the accumulator.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_y_q     <= '0;
            flags_q     <= '0;
            acc_q       <= '0;
            op_count_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_y_q     <= out_y_d;
            flags_q     <= flags_d;
            acc_q       <= acc_d;
            op_count_q  <= op_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_y     = out_y_q;
    assign out_zero  = flags_q.zero;
    assign out_ones  = flags_q.ones;
    assign out_par   = flags_q.par;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb_logic_unit_pipe
// Directed self-checking bench for logic_unit_pipe (WIDTH=8, CNT_W=4 so the
// counter wrap is reachable in a short run).
module tb_logic_unit_pipe;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_op;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       in_acc;
    logic       in_clr;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_y;
    logic       out_zero;
    logic       out_ones;
    logic       out_par;
    logic [7:0] acc_q;
    logic [3:0] op_count;

    int checks = 0;
    int errors = 0;
    logic readyBeforeEdge;

    logic_unit_pipe #(
        .WIDTH (8),
        .CNT_W (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_acc    (in_acc),
        .in_clr    (in_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_zero  (out_zero),
        .out_ones  (out_ones),
        .out_par   (out_par),
        .acc_q     (acc_q),
        .op_count  (op_count)
    );

    // 10 ns clock period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one cycle of inputs, samples the combinational in_ready before
    // the edge, then lets the edge happen and settles 1 ns past it.
    task automatic applyStimulus(
        input logic [2:0] op,
        input logic [7:0] a,
        input logic [7:0] b,
        input logic       acc,
        input logic       clr,
        input logic       valid,
        input logic       oready
    );
        in_op     = op;
        in_a      = a;
        in_b      = b;
        in_acc    = acc;
        in_clr    = clr;
        in_valid  = valid;
        out_ready = oready;
        #1;
        readyBeforeEdge = in_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(
        input string       tag,
        input logic [31:0] observed,
        input logic [31:0] expected
    );
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    logic [7:0] sweepExp [8];

    initial begin
        sweepExp[0] = 8'h5A; sweepExp[1] = 8'h24; sweepExp[2] = 8'hBD; sweepExp[3] = 8'hDB;
        sweepExp[4] = 8'h42; sweepExp[5] = 8'h99; sweepExp[6] = 8'h66; sweepExp[7] = 8'h3C;

        // ---- reset: in_ready held low even with a valid beat offered ----
        rst = 1'b1;
        applyStimulus(3'd2, 8'h11, 8'h22, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("rst_in_ready", 32'(readyBeforeEdge), 32'd0);
        applyStimulus(3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_y", 32'(out_y), 32'h00);
        checkOutput("rst_flags", 32'({out_zero, out_ones, out_par}), 32'd0);
        checkOutput("rst_acc", 32'(acc_q), 32'h00);
        checkOutput("rst_count", 32'(op_count), 32'd0);
        rst = 1'b0;

        // ---- opcode sweep, back-to-back ----
        for (int i = 0; i < 8; i++) begin
            applyStimulus(3'(i), 8'hA5, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b1);
            checkOutput($sformatf("sweep_ready_%0d", i), 32'(readyBeforeEdge), 32'd1);
            checkOutput($sformatf("sweep_valid_%0d", i), 32'(out_valid), 32'd1);
            checkOutput($sformatf("sweep_y_%0d", i), 32'(out_y), 32'(sweepExp[i]));
        end
        checkOutput("sweep_count", 32'(op_count), 32'd8);
        applyStimulus(3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("drain_valid", 32'(out_valid), 32'd0);

        // ---- flags: {zero, ones, par} ----
        applyStimulus(3'd2, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("flag_zero_y", 32'(out_y), 32'h00);
        checkOutput("flag_zero", 32'({out_zero, out_ones, out_par}), 32'b100);
        applyStimulus(3'd1, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("flag_ones_y", 32'(out_y), 32'hFF);
        checkOutput("flag_ones", 32'({out_zero, out_ones, out_par}), 32'b010);
        applyStimulus(3'd7, 8'hAA, 8'h07, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("flag_par_y", 32'(out_y), 32'h07);
        checkOutput("flag_par", 32'({out_zero, out_ones, out_par}), 32'b001);
        applyStimulus(3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("flags_count", 32'(op_count), 32'd11);

        // ---- backpressure ----
        applyStimulus(3'd5, 8'h0F, 8'hF0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("bp_first_y", 32'(out_y), 32'hFF);
        checkOutput("bp_first_count", 32'(op_count), 32'd12);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(3'd1, 8'h3C, 8'h0F, 1'b0, 1'b0, 1'b1, 1'b0);
            checkOutput($sformatf("bp_ready_%0d", i), 32'(readyBeforeEdge), 32'd0);
            checkOutput($sformatf("bp_valid_%0d", i), 32'(out_valid), 32'd1);
            checkOutput($sformatf("bp_hold_y_%0d", i), 32'(out_y), 32'hFF);
            checkOutput($sformatf("bp_hold_flags_%0d", i), 32'({out_zero, out_ones, out_par}), 32'b010);
            checkOutput($sformatf("bp_count_%0d", i), 32'(op_count), 32'd12);
        end
        applyStimulus(3'd1, 8'h3C, 8'h0F, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("bp_release_ready", 32'(readyBeforeEdge), 32'd1);
        checkOutput("bp_release_valid", 32'(out_valid), 32'd1);
        checkOutput("bp_release_y", 32'(out_y), 32'h0C);
        checkOutput("bp_release_count", 32'(op_count), 32'd13);

        // ---- accumulator chain ----
        applyStimulus(3'd2, 8'hEE, 8'h01, 1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("acc1_y", 32'(out_y), 32'h01);
        checkOutput("acc1_acc", 32'(acc_q), 32'h01);
        applyStimulus(3'd5, 8'hEE, 8'h03, 1'b1, 1'b0, 1'b1, 1'b1);
        checkOutput("acc2_y", 32'(out_y), 32'h02);
        checkOutput("acc2_acc", 32'(acc_q), 32'h02);
        applyStimulus(3'd1, 8'hEE, 8'hF0, 1'b1, 1'b0, 1'b1, 1'b1);
        checkOutput("acc3_y", 32'(out_y), 32'h00);
        checkOutput("acc3_acc", 32'(acc_q), 32'h00);
        applyStimulus(3'd2, 8'hEE, 8'h55, 1'b1, 1'b0, 1'b1, 1'b1);
        checkOutput("acc4_acc", 32'(acc_q), 32'h55);
        applyStimulus(3'd2, 8'h12, 8'h21, 1'b0, 1'b1, 1'b1, 1'b1);
        checkOutput("accclr_y", 32'(out_y), 32'h33);
        checkOutput("accclr_acc", 32'(acc_q), 32'h00);
        checkOutput("acc_count_wrapped", 32'(op_count), 32'd2);

        // ---- mid-operation reset ----
        applyStimulus(3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(3'd2, 8'h00, 8'h55, 1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("pre_rst_acc", 32'(acc_q), 32'h55);
        checkOutput("pre_rst_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        applyStimulus(3'd2, 8'h00, 8'h55, 1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("mid_rst_ready", 32'(readyBeforeEdge), 32'd0);
        checkOutput("mid_rst_valid", 32'(out_valid), 32'd0);
        checkOutput("mid_rst_acc", 32'(acc_q), 32'h00);
        checkOutput("mid_rst_count", 32'(op_count), 32'd0);
        rst = 1'b0;

        // ---- counter wrap: 17 beats into a 4-bit counter ----
        for (int i = 0; i < 17; i++) begin
            applyStimulus(3'd7, 8'h00, 8'(i), 1'b0, 1'b0, 1'b1, 1'b1);
            if (i == 15) begin
                checkOutput("wrap_count_16", 32'(op_count), 32'd0);
            end
        end
        checkOutput("wrap_count_17", 32'(op_count), 32'd1);
        checkOutput("wrap_last_y", 32'(out_y), 32'h10);

        applyStimulus(3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
